matmul_job_seq: RTL
===================

Name: matmul_job_seq

Overview:
- Upstream command stage for the matmul engine.
- Walks a list of job descriptors in memory over its own simple memory port and loads each descriptor's nine dimension/base/stride fields onto the engine's configuration inputs.
- For each valid job: pulses the engine's go, waits for its ret, then writes a completion flag back into the descriptor.
- Signals done when the list ends.

Parameters:
- DIM_BITS, 16, width of row/col/stride fields driven to the engine.
- MEM_AW, 16, memory address width.
- MEM_DW, 32, memory data width; must be ≥ max(MEM_AW, DIM_BITS, 3).
- DESC_STRIDE, 16, word distance between consecutive descriptors.
- MAX_JOBS_BITS, 8, width of the job count and counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; accepted only in IDLE
- desc_base  in  MEM_AW  address of descriptor 0; sampled on start
- desc_count  in  MAX_JOBS_BITS  maximum descriptors to walk; sampled on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of list
- jobs_run  out  MAX_JOBS_BITS  jobs launched since last start
- jobs_skipped  out  MAX_JOBS_BITS  invalid descriptors skipped
- mem_addr  out  MEM_AW  sequencer memory address
- mem_req  out  1  request strobe
- mem_write  out  1  1 = write, 0 = read
- mem_wdata  out  MEM_DW  write data
- mem_rdata  in  MEM_DW  read data
- mm_aBASE, mm_bBASE, mm_cBASE  out  MEM_AW  engine config
- mm_aCOLS, mm_aROWS, mm_aSTRIDE, mm_bCOLS, mm_bSTRIDE, mm_cSTRIDE  out  DIM_BITS  engine config
- mm_go  out  1  engine start pulse
- mm_ret  in  1  engine completion pulse

Behaviour:
- All outputs are registered. Reset value of every output and internal register is 0; FSM resets to IDLE. Reset mid-operation aborts immediately with no write-back.
- Memory protocol:
  - A request is presented when mem_req=1 in cycle N.
  - For a read, mem_rdata is valid in cycle N+1 and is sampled at the end of N+1.
  - Back-to-back requests are allowed, one per cycle. No stall.
- Descriptor layout (word offsets from the descriptor address D):
  - 0: ctrl. bit0 valid, bit1 last, bit2 done.
  - 1: aBASE, 2: aCOLS, 3: aROWS, 4: aSTRIDE, 5: bBASE, 6: bCOLS, 7: bSTRIDE, 8: cBASE, 9: cSTRIDE.
  - Each field is taken from the low bits of its word.
- States:
  - IDLE: on start, latch desc_base→D and desc_count→remaining, clear both counters, set busy → FETCH. If desc_count=0, go straight to FIN.
  - FETCH: issue reads of D+0 … D+9 on 10 consecutive cycles. Each returning word is captured into ctrl or the matching mm_* register one cycle later. After the last capture → CHECK. The mm_* outputs update only here.
  - CHECK:
    - valid=0: jobs_skipped++, then → NEXT. If last is also set, the walk ends (→ FIN).
    - valid=1: → LAUNCH.
  - LAUNCH: mm_go=1 for exactly one cycle, jobs_run++ → WAIT_RET. mm_* must stay stable from LAUNCH until mm_ret.
  - WAIT_RET: wait for mm_ret=1 → WRBACK. If mm_ret arrives in the same cycle as mm_go, it is ignored.
  - WRBACK: single write to D+0 with data {ctrl[MEM_DW-1:3], 1'b1, ctrl[1:0]}, then → GUARD.
  - GUARD: two idle cycles, because the engine needs two cycles after ret to re-enter its go-sampling state. Then → NEXT.
  - NEXT: remaining--. If last was set or remaining reaches 0 → FIN. Otherwise D += DESC_STRIDE (wraps modulo 2^MEM_AW) → FETCH.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- mm_go only ever fires from LAUNCH. Counters saturate at all-ones.
- start while busy is ignored.
- mem_req is 0 outside FETCH and WRBACK.
- Fields wider than the port are truncated to the port width.

Decomposition:
- Shared package: FSM state encoding and descriptor word offsets (DESC_CTRL…DESC_CSTRIDE, CTRL_VALID/LAST/DONE bit indices). The matmul testbench reuses these.
- One natural sub-module: matmul_desc_regs. It decodes the returning word index and captures it into ctrl and the nine mm_* registers. Everything else stays in the main FSM.

Test Plan:
- Single valid job at base 0x100 (aROWS=2, aCOLS=3, bCOLS=2), count=1:
  - Reads 0x100–0x109, mm_go pulses once with fields matching the descriptor.
  - After mm_ret: write to 0x100 with bit2 set, GUARD of 2 cycles, done pulse; jobs_run=1.
- Three descriptors at 0x200, 0x210, 0x220 with the middle one valid=0, count=3:
  - Two launches, jobs_skipped=1, no write to 0x210.
- last bit set on descriptor 1 of count=5:
  - Walk stops after descriptor 1; jobs_run=2; no reads at D+2·DESC_STRIDE.
- Wrap: desc_base=0xFFF0 with MEM_AW=16, count=2:
  - Second descriptor fetched from 0x0000.
- Reset asserted during WAIT_RET:
  - All outputs 0 on the next cycle; no write-back.
  - A new start runs cleanly from IDLE.
- start pulsed during busy, and desc_count=0:
  - The busy start is ignored.
  - The count=0 case gives done one cycle after IDLE with zero memory requests.

Source files
------------

// File: rtl/matmul_job_seq_pkg.sv
// Shared definitions for the matmul job sequencer: FSM encoding and the
// word layout of a job descriptor in memory.
package matmul_job_seq_pkg;

  // state       | meaning
  // ST_IDLE     | waiting for start
  // ST_FETCH    | reading the ten descriptor words, capturing one cycle behind
  // ST_CHECK    | deciding between launch and skip on the ctrl word
  // ST_LAUNCH   | mm_go pulse
  // ST_WAIT_RET | waiting for the engine's mm_ret
  // ST_WRBACK   | writing ctrl back with the done bit set
  // ST_GUARD    | two quiet cycles so the engine can re-arm
  // ST_NEXT     | advance to the next descriptor or finish
  // ST_FIN      | done pulse, then back to idle
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_CHECK    = 4'd2,
    ST_LAUNCH   = 4'd3,
    ST_WAIT_RET = 4'd4,
    ST_WRBACK   = 4'd5,
    ST_GUARD    = 4'd6,
    ST_NEXT     = 4'd7,
    ST_FIN      = 4'd8
  } seq_state_t;

  // Word offsets inside a descriptor.
  localparam logic [3:0] DESC_CTRL    = 4'd0;
  localparam logic [3:0] DESC_ABASE   = 4'd1;
  localparam logic [3:0] DESC_ACOLS   = 4'd2;
  localparam logic [3:0] DESC_AROWS   = 4'd3;
  localparam logic [3:0] DESC_ASTRIDE = 4'd4;
  localparam logic [3:0] DESC_BBASE   = 4'd5;
  localparam logic [3:0] DESC_BCOLS   = 4'd6;
  localparam logic [3:0] DESC_BSTRIDE = 4'd7;
  localparam logic [3:0] DESC_CBASE   = 4'd8;
  localparam logic [3:0] DESC_CSTRIDE = 4'd9;
  localparam logic [3:0] DESC_WORDS   = 4'd10;

  // Bit positions inside the ctrl word.
  localparam int CTRL_VALID = 0;
  localparam int CTRL_LAST  = 1;
  localparam int CTRL_DONE  = 2;

  // Guard timer load value: counts down to 0, giving two GUARD cycles.
  localparam logic [1:0] GUARD_LOAD = 2'd1;

endpackage

// File: rtl/matmul_job_seq_if.sv
// Memory port and engine configuration/handshake bundle of the sequencer.
interface matmul_job_seq_if #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DIM_BITS = 16
);
  logic [MEM_AW-1:0]   mem_addr;
  logic                mem_req;
  logic                mem_write;
  logic [MEM_DW-1:0]   mem_wdata;
  logic [MEM_DW-1:0]   mem_rdata;

  logic [MEM_AW-1:0]   mm_aBASE;
  logic [MEM_AW-1:0]   mm_bBASE;
  logic [MEM_AW-1:0]   mm_cBASE;
  logic [DIM_BITS-1:0] mm_aCOLS;
  logic [DIM_BITS-1:0] mm_aROWS;
  logic [DIM_BITS-1:0] mm_aSTRIDE;
  logic [DIM_BITS-1:0] mm_bCOLS;
  logic [DIM_BITS-1:0] mm_bSTRIDE;
  logic [DIM_BITS-1:0] mm_cSTRIDE;
  logic                mm_go;
  logic                mm_ret;

  modport master (
    output mem_addr, mem_req, mem_write, mem_wdata,
    input  mem_rdata,
    output mm_aBASE, mm_bBASE, mm_cBASE,
    output mm_aCOLS, mm_aROWS, mm_aSTRIDE, mm_bCOLS, mm_bSTRIDE, mm_cSTRIDE,
    output mm_go,
    input  mm_ret
  );

  modport slave (
    input  mem_addr, mem_req, mem_write, mem_wdata,
    output mem_rdata,
    input  mm_aBASE, mm_bBASE, mm_cBASE,
    input  mm_aCOLS, mm_aROWS, mm_aSTRIDE, mm_bCOLS, mm_bSTRIDE, mm_cSTRIDE,
    input  mm_go,
    output mm_ret
  );
endinterface

// File: rtl/matmul_desc_regs.sv
// Descriptor capture registers: each returning read word is routed by its
// word index into ctrl or one of the engine configuration registers.
module matmul_desc_regs
  import matmul_job_seq_pkg::*;
#(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DIM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cap_en_i,
  input  logic [3:0]          cap_idx_i,
  input  logic [MEM_DW-1:0]   rdata_i,
  output logic [MEM_DW-1:0]   ctrl_o,
  output logic [MEM_AW-1:0]   a_base_o,
  output logic [DIM_BITS-1:0] a_cols_o,
  output logic [DIM_BITS-1:0] a_rows_o,
  output logic [DIM_BITS-1:0] a_stride_o,
  output logic [MEM_AW-1:0]   b_base_o,
  output logic [DIM_BITS-1:0] b_cols_o,
  output logic [DIM_BITS-1:0] b_stride_o,
  output logic [MEM_AW-1:0]   c_base_o,
  output logic [DIM_BITS-1:0] c_stride_o
);

  logic [MEM_DW-1:0]   ctrl_q;
  logic [MEM_AW-1:0]   a_base_q, b_base_q, c_base_q;
  logic [DIM_BITS-1:0] a_cols_q, a_rows_q, a_stride_q;
  logic [DIM_BITS-1:0] b_cols_q, b_stride_q, c_stride_q;

  // Capture the word named by cap_idx_i; fields keep only their low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      a_base_q   <= '0;
      a_cols_q   <= '0;
      a_rows_q   <= '0;
      a_stride_q <= '0;
      b_base_q   <= '0;
      b_cols_q   <= '0;
      b_stride_q <= '0;
      c_base_q   <= '0;
      c_stride_q <= '0;
    end else if (cap_en_i) begin
      case (cap_idx_i)
        DESC_CTRL:    ctrl_q     <= rdata_i;
        DESC_ABASE:   a_base_q   <= rdata_i[MEM_AW-1:0];
        DESC_ACOLS:   a_cols_q   <= rdata_i[DIM_BITS-1:0];
        DESC_AROWS:   a_rows_q   <= rdata_i[DIM_BITS-1:0];
        DESC_ASTRIDE: a_stride_q <= rdata_i[DIM_BITS-1:0];
        DESC_BBASE:   b_base_q   <= rdata_i[MEM_AW-1:0];
        DESC_BCOLS:   b_cols_q   <= rdata_i[DIM_BITS-1:0];
        DESC_BSTRIDE: b_stride_q <= rdata_i[DIM_BITS-1:0];
        DESC_CBASE:   c_base_q   <= rdata_i[MEM_AW-1:0];
        DESC_CSTRIDE: c_stride_q <= rdata_i[DIM_BITS-1:0];
        default: ;
      endcase
    end
  end

  assign ctrl_o     = ctrl_q;
  assign a_base_o   = a_base_q;
  assign a_cols_o   = a_cols_q;
  assign a_rows_o   = a_rows_q;
  assign a_stride_o = a_stride_q;
  assign b_base_o   = b_base_q;
  assign b_cols_o   = b_cols_q;
  assign b_stride_o = b_stride_q;
  assign c_base_o   = c_base_q;
  assign c_stride_o = c_stride_q;

endmodule

// File: rtl/matmul_job_seq.sv
// Matmul job sequencer: walks a descriptor list, loads each valid job into
// the engine, launches it, waits for completion and marks it done in memory.
// Memory and handshake outputs are registered from the next-state decode so
// they are valid for the whole cycle of the state that owns them.
module matmul_job_seq
  import matmul_job_seq_pkg::*;
#(
  parameter int DIM_BITS      = 16,
  parameter int MEM_AW        = 16,
  parameter int MEM_DW        = 32,
  parameter int DESC_STRIDE   = 16,
  parameter int MAX_JOBS_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [MEM_AW-1:0]        desc_base,
  input  logic [MAX_JOBS_BITS-1:0] desc_count,
  output logic                     busy,
  output logic                     done,
  output logic [MAX_JOBS_BITS-1:0] jobs_run,
  output logic [MAX_JOBS_BITS-1:0] jobs_skipped,
  matmul_job_seq_if.master         bus
);

  seq_state_t               state_q, state_d;
  logic [MEM_AW-1:0]        d_q, d_d;
  logic [MAX_JOBS_BITS-1:0] rem_q, rem_d;
  logic [MAX_JOBS_BITS-1:0] run_q, run_d;
  logic [MAX_JOBS_BITS-1:0] skip_q, skip_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [1:0]               guard_q, guard_d;

  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     go_q, go_d;
  logic                     req_q, req_d;
  logic                     wr_q, wr_d;
  logic [MEM_AW-1:0]        addr_q, addr_d;
  logic [MEM_DW-1:0]        wdata_q, wdata_d;

  logic                     cap_en;
  logic [3:0]               cap_idx;
  logic [MEM_DW-1:0]        ctrl;

  logic [MEM_AW-1:0]        a_base, b_base, c_base;
  logic [DIM_BITS-1:0]      a_cols, a_rows, a_stride;
  logic [DIM_BITS-1:0]      b_cols, b_stride, c_stride;

  matmul_desc_regs #(
    .MEM_AW   (MEM_AW),
    .MEM_DW   (MEM_DW),
    .DIM_BITS (DIM_BITS)
  ) u_desc_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en_i   (cap_en),
    .cap_idx_i  (cap_idx),
    .rdata_i    (bus.mem_rdata),
    .ctrl_o     (ctrl),
    .a_base_o   (a_base),
    .a_cols_o   (a_cols),
    .a_rows_o   (a_rows),
    .a_stride_o (a_stride),
    .b_base_o   (b_base),
    .b_cols_o   (b_cols),
    .b_stride_o (b_stride),
    .c_base_o   (c_base),
    .c_stride_o (c_stride)
  );

  // Next-state decode plus the registered-output values for the next cycle.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    rem_d   = rem_q;
    run_d   = run_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    guard_d = guard_q;
    cap_en  = 1'b0;
    cap_idx = cnt_q - 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          d_d    = desc_base;
          rem_d  = desc_count;
          run_d  = '0;
          skip_d = '0;
          cnt_d  = '0;
          state_d = (desc_count == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Cycle k issues word k and captures word k-1 returned from the
        // previous cycle; the extra final cycle only drains word 9.
        cap_en = (cnt_q != 4'd0);
        if (cnt_q == DESC_WORDS) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (ctrl[CTRL_VALID]) begin
          run_d   = (&run_q) ? run_q : run_q + 1'b1;
          state_d = ST_LAUNCH;
        end else begin
          skip_d  = (&skip_q) ? skip_q : skip_q + 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_LAUNCH: begin
        // mm_ret is not looked at here, so a ret coincident with go is dropped.
        state_d = ST_WAIT_RET;
      end
      ST_WAIT_RET: begin
        if (bus.mm_ret) state_d = ST_WRBACK;
      end
      ST_WRBACK: begin
        guard_d = GUARD_LOAD;
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_q == 2'd0) state_d = ST_NEXT;
        else                 guard_d = guard_q - 2'd1;
      end
      ST_NEXT: begin
        rem_d = rem_q - 1'b1;
        if (ctrl[CTRL_LAST] || rem_q == MAX_JOBS_BITS'(1)) begin
          state_d = ST_FIN;
        end else begin
          d_d     = d_q + MEM_AW'(DESC_STRIDE);
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
    go_d    = (state_d == ST_LAUNCH);
    wr_d    = (state_d == ST_WRBACK);
    req_d   = ((state_d == ST_FETCH) && (cnt_d < DESC_WORDS)) || wr_d;
    addr_d  = '0;
    wdata_d = '0;
    if (wr_d) begin
      addr_d             = d_q;
      wdata_d            = ctrl;
      wdata_d[CTRL_DONE] = 1'b1;
    end else if (req_d) begin
      addr_d = d_d + MEM_AW'(cnt_d);
    end
  end

  // State, walk bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      rem_q   <= '0;
      run_q   <= '0;
      skip_q  <= '0;
      cnt_q   <= '0;
      guard_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      run_q   <= run_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      go_q    <= go_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign jobs_run       = run_q;
  assign jobs_skipped   = skip_q;

  assign bus.mem_req    = req_q;
  assign bus.mem_write  = wr_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mm_go      = go_q;

  assign bus.mm_aBASE   = a_base;
  assign bus.mm_aCOLS   = a_cols;
  assign bus.mm_aROWS   = a_rows;
  assign bus.mm_aSTRIDE = a_stride;
  assign bus.mm_bBASE   = b_base;
  assign bus.mm_bCOLS   = b_cols;
  assign bus.mm_bSTRIDE = b_stride;
  assign bus.mm_cBASE   = c_base;
  assign bus.mm_cSTRIDE = c_stride;

endmodule
